// File: rtl/uart_core.sv
// uart_core: single-clock full-duplex UART with internal baud-tick generation.
//
// Each direction owns a private clk divider (0..CLK_DIV-1) that produces an
// oversample tick; OVERSAMPLE ticks make one bit period. Frames are
// start, DATA_BITS data bits LSB first, optional parity, stop bit(s).
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-low reset
//   rx            serial input (asynchronous, idle high)
//   send          transmit request, accepted only while the transmitter is idle
//   to_send       transmit payload, captured when send is accepted
//   tx            serial output (idle high)
//   tx_busy       transmit frame in progress
//   tx_done       one-cycle pulse at the end of the last stop bit
//   rx_drdy       one-cycle pulse when received/error flags update
//   received      last received payload
//   rx_frame_err  first stop bit of last frame was sampled 0
//   rx_parity_err parity mismatch on last frame (0 when PARITY=0)
module uart_core #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] to_send,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 rx_drdy,
  output logic [DATA_BITS-1:0] received,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       DATA_LAST    = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST    = 1'(STOP_BITS - 1);
  localparam logic             HAS_PAR      = (PARITY != 0);
  localparam logic             PAR_ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- TX
  state_t                tx_state;
  logic [DIV_W-1:0]      tx_div;
  logic [OS_W-1:0]       tx_os;
  logic [3:0]            tx_bit;
  logic                  tx_stop;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic                  tx_tick;
  logic                  tx_bit_end;

  assign tx_tick    = (tx_div == DIV_LAST);
  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

  // The divider is held clear while idle so every frame starts with a
  // full-length start bit counted from the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_div   <= '0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == S_IDLE) begin
        tx_div <= '0;
        tx_os  <= '0;
      end else begin
        tx_div <= tx_tick ? '0 : tx_div + DIV_W'(1);
        if (tx_tick) tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + OS_W'(1);
      end
      case (tx_state)
        S_IDLE: begin
          if (send) begin
            tx_shift <= to_send;
            tx_par   <= ^to_send ^ PAR_ODD;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == DATA_LAST) begin
              tx_stop <= 1'b0;
              if (HAS_PAR) begin
                tx       <= tx_par;
                tx_state <= S_PARITY;
              end else begin
                tx       <= 1'b1;
                tx_state <= S_STOP;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tx_bit_end) begin
            tx       <= 1'b1;
            tx_stop  <= 1'b0;
            tx_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop == STOP_LAST) begin
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_state <= S_IDLE;
            end else begin
              tx_stop <= 1'b1;
            end
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic                  rx_meta;
  logic                  rx_sync;
  state_t                rx_state;
  logic [DIV_W-1:0]      rx_div;
  logic [OS_W-1:0]       rx_os;
  logic [3:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par_bit;
  logic                  rx_stop_bit;
  logic                  rx_pend;
  logic                  rx_tick;
  logic                  rx_mid;
  logic                  rx_sample;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_tick   = (rx_div == DIV_LAST);
  assign rx_mid    = rx_tick && (rx_os == OS_HALF_LAST);
  assign rx_sample = rx_tick && (rx_os == OS_LAST);

  // START waits half a bit to reach the bit centre and restarts the tick
  // count there, so later samples land one full bit apart at bit centres.
  // The stop sample only arms rx_pend; outputs update one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state      <= S_IDLE;
      rx_div        <= '0;
      rx_os         <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_stop_bit   <= 1'b1;
      rx_pend       <= 1'b0;
      rx_drdy       <= 1'b0;
      received      <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_drdy <= 1'b0;
      if (rx_pend) begin
        rx_pend       <= 1'b0;
        rx_drdy       <= 1'b1;
        received      <= rx_shift;
        rx_frame_err  <= ~rx_stop_bit;
        rx_parity_err <= HAS_PAR ? (^rx_shift ^ rx_par_bit ^ PAR_ODD) : 1'b0;
      end
      if (rx_state == S_IDLE) begin
        rx_div <= '0;
        rx_os  <= '0;
      end else begin
        rx_div <= rx_tick ? '0 : rx_div + DIV_W'(1);
        if (rx_tick) rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + OS_W'(1);
      end
      case (rx_state)
        S_IDLE: begin
          if (!rx_sync) rx_state <= S_START;
        end
        S_START: begin
          if (rx_mid) begin
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (rx_sample) begin
            rx_par_bit <= rx_sync;
            rx_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_sample) begin
            rx_stop_bit <= rx_sync;
            rx_pend     <= 1'b1;
            rx_state    <= S_IDLE;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule
